// File: rtl/hba_pkg.sv
// hba_pkg: shared definitions for the HBA bus arbiter.
//   arb_state_e      - arbiter FSM states (IDLE / GRANT / GAP)
//   HBA_MAX_MASTERS  - largest supported master count
//   HBA_IDX_W        - width of a master index (grant_id, last_owner)
//   HBA_WDOG_W       - width of the grant-hold watchdog counter
package hba_pkg;

    localparam int HBA_MAX_MASTERS = 8;
    localparam int HBA_IDX_W       = 3;
    localparam int HBA_WDOG_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/hba_rr_picker.sv
// hba_rr_picker: combinational round-robin selector.
//   req        - request vector (already masked by the caller)
//   last_owner - index of the most recent owner; search starts just after it
//   pick       - one-hot winner (zero when nothing requests)
//   pick_idx   - index of the winner (zero when nothing requests)
//   pick_vld   - a winner exists
module hba_rr_picker
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [HBA_IDX_W-1:0]   last_owner,
    output logic [NUM_MASTERS-1:0] pick,
    output logic [HBA_IDX_W-1:0]   pick_idx,
    output logic                   pick_vld
);

    // Walk the ring at distance 1..NUM_MASTERS from last_owner; the first
    // requester met wins. last_owner itself is reached last (distance N).
    // Constant loop bounds keep every bit-select static.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!pick_vld && req[i] &&
                    (i == (int'(last_owner) + k) % NUM_MASTERS)) begin
                    pick_vld = 1'b1;
                    pick[i]  = 1'b1;
                    pick_idx = HBA_IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin bus arbiter for NUM_MASTERS HBA masters.
//   hba_clk        - bus clock, rising edge
//   hba_reset_n    - asynchronous active-low reset
//   master_request - per-master bus request
//   hba_mgrant     - registered one-hot-or-zero grant
//   grant_id       - index of the granted master, 0 when none
//   arb_busy       - high while a grant is asserted
//   arb_timeout    - one-cycle pulse on watchdog revoke (HBA_ARB_WATCHDOG_EN only)
// Build option: define HBA_ARB_WATCHDOG_EN to add the grant-hold watchdog,
// the post-revoke block mask and the arb_timeout port.
module hba_arbiter
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset_n,
    input  logic [NUM_MASTERS-1:0] master_request,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic [HBA_IDX_W-1:0]   grant_id,
    output logic                   arb_busy
`ifdef HBA_ARB_WATCHDOG_EN
    ,
    output logic                   arb_timeout
`endif
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > HBA_MAX_MASTERS) begin : g_bad_num_masters
        $error("hba_arbiter: NUM_MASTERS out of range 2..8");
    end
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_wdog_cycles
        $error("hba_arbiter: WDOG_CYCLES out of range 1..65535");
    end

    arb_state_e                 state, state_d;
    logic [NUM_MASTERS-1:0]     mgrant_d;
    logic [HBA_IDX_W-1:0]       gid_d;
    logic                       busy_d;
    logic [HBA_IDX_W-1:0]       last_owner, last_d;

    logic [NUM_MASTERS-1:0]     eff_req;
    logic [NUM_MASTERS-1:0]     pick;
    logic [HBA_IDX_W-1:0]       pick_idx;
    logic                       pick_vld;
    logic                       owner_req;
    logic                       wdog_expired;

    // The owner is whoever holds the grant, so its request is found by
    // masking rather than by indexing with last_owner.
    assign owner_req = |(master_request & hba_mgrant);

`ifdef HBA_ARB_WATCHDOG_EN
    localparam logic [HBA_WDOG_W-1:0] WDOG_LIMIT = HBA_WDOG_W'(WDOG_CYCLES - 1);

    logic [HBA_WDOG_W-1:0]  wdog_cnt, wdog_d;
    logic [NUM_MASTERS-1:0] blk_mask, blk_d;
    logic                   revoke;

    // wdog_cnt counts completed GRANT cycles, so expiry on LIMIT = N-1
    // leaves the grant visible for exactly WDOG_CYCLES cycles.
    assign wdog_expired = (wdog_cnt >= WDOG_LIMIT);
    // A release in the expiry cycle wins: revoke only with the request still up.
    assign revoke       = (state == GRANT) && owner_req && wdog_expired;
    assign eff_req      = master_request & ~blk_mask;

    always_comb begin
        wdog_d = '0;
        if (state == GRANT)
            wdog_d = (wdog_cnt == {HBA_WDOG_W{1'b1}}) ? wdog_cnt : wdog_cnt + 1'b1;
        // A blocked master is freed once it drops its request.
        blk_d = (blk_mask & master_request) | (revoke ? hba_mgrant : '0);
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            wdog_cnt    <= '0;
            blk_mask    <= '0;
            arb_timeout <= 1'b0;
        end else begin
            wdog_cnt    <= wdog_d;
            blk_mask    <= blk_d;
            arb_timeout <= revoke;
        end
    end
`else
    assign wdog_expired = 1'b0;
    assign eff_req      = master_request;
`endif

    hba_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req        (eff_req),
        .last_owner (last_owner),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_vld   (pick_vld)
    );

    // GAP is the single dead cycle after a release; its closing edge also
    // performs the IDLE selection so back-to-back requesters see exactly
    // one all-zero cycle. With nothing pending it settles in IDLE.
    always_comb begin
        state_d  = state;
        mgrant_d = hba_mgrant;
        gid_d    = grant_id;
        busy_d   = arb_busy;
        last_d   = last_owner;
        case (state)
            IDLE, GAP: begin
                state_d = IDLE;
                if (pick_vld) begin
                    state_d  = GRANT;
                    mgrant_d = pick;
                    gid_d    = pick_idx;
                    busy_d   = 1'b1;
                    last_d   = pick_idx;
                end
            end
            GRANT: begin
                if (!owner_req || wdog_expired) begin
                    state_d  = GAP;
                    mgrant_d = '0;
                    gid_d    = '0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                mgrant_d = '0;
                gid_d    = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state      <= IDLE;
            hba_mgrant <= '0;
            grant_id   <= '0;
            arb_busy   <= 1'b0;
            last_owner <= HBA_IDX_W'(NUM_MASTERS - 1);
        end else begin
            state      <= state_d;
            hba_mgrant <= mgrant_d;
            grant_id   <= gid_d;
            arb_busy   <= busy_d;
            last_owner <= last_d;
        end
    end

endmodule

// File: tb/tb_hba_arbiter.sv
// tb_hba_arbiter: self-checking bench for hba_arbiter (NUM_MASTERS=4,
// WDOG_CYCLES=10). Outputs are compared against a behavioural model of the
// arbitration rules every cycle, plus directed checks per scenario.
module tb_hba_arbiter;

    localparam int N = 4;
    localparam int W = 10;
`ifdef HBA_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         hba_clk = 1'b0;
    logic         hba_reset_n = 1'b0;
    logic [N-1:0] master_request = '0;
    logic [N-1:0] hba_mgrant;
    logic [2:0]   grant_id;
    logic         arb_busy;
`ifdef HBA_ARB_WATCHDOG_EN
    logic         arb_timeout;
`else
    wire          arb_timeout = 1'b0;
`endif

    hba_arbiter #(
        .NUM_MASTERS (N),
        .WDOG_CYCLES (W)
    ) dut (
        .hba_clk        (hba_clk),
        .hba_reset_n    (hba_reset_n),
        .master_request (master_request),
        .hba_mgrant     (hba_mgrant),
        .grant_id       (grant_id),
        .arb_busy       (arb_busy)
`ifdef HBA_ARB_WATCHDOG_EN
        ,
        .arb_timeout    (arb_timeout)
`endif
    );

    always #5 hba_clk = ~hba_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: who owns the bus, how long it has held it, whether
    // this cycle is the dead cycle after a release, and who is blocked.
    int           m_owner;
    int           m_last;
    int           m_held;
    bit           m_gap;
    bit           m_to;
    logic [N-1:0] m_blk;

    wire [N+4:0] obs = {hba_mgrant, grant_id, arb_busy, arb_timeout};

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
        m_blk   = '0;
    endtask

    // Advance the model by one clock, given the request seen at that edge.
    task automatic model_step(input logic [N-1:0] req);
        logic [N-1:0] nb;
        bit           sel;
        nb   = m_blk & req;
        m_to = 1'b0;
        sel  = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
            sel   = 1'b1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (WD && m_held >= W) begin
                nb[m_owner] = 1'b1;
                m_to        = 1'b1;
                m_owner     = -1;
                m_gap       = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            sel = 1'b1;
        end
        if (sel) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c] && !m_blk[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end
        m_blk = nb;
    endtask

    function automatic logic [N+4:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 3'((m_owner >= 0) ? m_owner : 0), (m_owner >= 0), m_to};
    endfunction

    task automatic tick();
        model_step(master_request);
        @(posedge hba_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        hba_reset_n    = 1'b0;
        master_request = '0;
        @(posedge hba_clk);
        #1;
        hba_reset_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_reset();
        hba_reset_n    = 1'b0;
        master_request = '0;
        repeat (2) @(posedge hba_clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, '0);
        end
        hba_reset_n = 1'b1;
        model_reset();
        master_request = '0;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        master_request = 4'b0001;
        for (int c = 1; c <= 7; c++) begin
            if (c == 6) master_request = '0;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single c%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        // reconstructed timeline: c1..c5 granted, c6 dropped (GAP), c7 IDLE
    endtask

    task automatic test_single_directed();
        do_reset();
        master_request = 4'b0001;
        tick();
        checks++;
        if (hba_mgrant !== 4'b0001 || grant_id !== 3'd0 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_c1 got=%b/%0d want=0001/0", hba_mgrant, grant_id);
        end
        repeat (4) tick();
        master_request = '0;
        tick();
        checks++;
        if (hba_mgrant !== 4'b0000 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_c6 got=%b want=0000", hba_mgrant);
        end
    endtask

    task automatic test_rotation();
        int got[$];
        int run;
        int zeros;
        bit prev_g;
        do_reset();
        master_request = 4'b1111;
        run    = 0;
        zeros  = 0;
        prev_g = 1'b0;
        for (int i = 0; i < 60 && got.size() < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rotation c%0d got=%h want=%h", cyc, obs, exp_vec());
            end
            if (hba_mgrant != '0) begin
                if (!prev_g) begin
                    if (got.size() > 0) begin
                        checks++;
                        if (zeros !== 1) begin
                            errors++;
                            $display("FAIL rotation_gap got=%0d want=1", zeros);
                        end
                    end
                    got.push_back(int'(grant_id));
                    run = 0;
                end
                run++;
                if (run == 3) master_request[grant_id] = 1'b0;
                zeros  = 0;
                prev_g = 1'b1;
            end else begin
                master_request = 4'b1111;
                zeros++;
                prev_g = 1'b0;
            end
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL rotation_count got=%0d want=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != (i % 4)) begin
                    errors++;
                    $display("FAIL rotation_order[%0d] got=%0d want=%0d", i, got[i], i % 4);
                end
            end
        end
    endtask

    task automatic test_pending();
        do_reset();
        master_request = 4'b0100;
        repeat (3) tick();
        master_request = 4'b0110;
        repeat (3) begin
            tick();
            checks++;
            if (hba_mgrant !== 4'b0100 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL pending_hold got=%b want=0100", hba_mgrant);
            end
        end
        master_request = 4'b0010;
        tick();
        checks++;
        if (hba_mgrant !== 4'b0000) begin
            errors++;
            $display("FAIL pending_gap got=%b want=0000", hba_mgrant);
        end
        tick();
        checks++;
        if (hba_mgrant !== 4'b0010 || grant_id !== 3'd1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL pending_grant got=%b/%0d want=0010/1", hba_mgrant, grant_id);
        end
    endtask

`ifdef HBA_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int gcnt;
        int tcnt;
        do_reset();
        master_request = 4'b1000;
        gcnt = 0;
        tcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL wdog c%0d got=%h want=%h", cyc, obs, exp_vec());
            end
            if (hba_mgrant == 4'b1000) gcnt++;
            if (arb_timeout) tcnt++;
        end
        checks++;
        if (gcnt != W || tcnt != 1) begin
            errors++;
            $display("FAIL wdog_revoke got=%0d/%0d want=%0d/1", gcnt, tcnt, W);
        end
        master_request = '0;
        tick();
        master_request = 4'b1000;
        tick();
        checks++;
        if (hba_mgrant !== 4'b1000) begin
            errors++;
            $display("FAIL wdog_regrant got=%b want=1000", hba_mgrant);
        end
        // Release coinciding with expiry counts as a normal release.
        repeat (W - 1) tick();
        master_request = '0;
        tick();
        checks++;
        if (hba_mgrant !== 4'b0000 || arb_timeout !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL wdog_release got=%b/%b want=0000/0", hba_mgrant, arb_timeout);
        end
        master_request = 4'b1000;
        tick();
        checks++;
        if (hba_mgrant !== 4'b1000) begin
            errors++;
            $display("FAIL wdog_noblock got=%b want=1000", hba_mgrant);
        end
    endtask
`else
    task automatic test_hold();
        int gcnt;
        do_reset();
        master_request = 4'b1000;
        gcnt = 0;
        repeat (40) begin
            tick();
            if (hba_mgrant == 4'b1000) gcnt++;
        end
        checks++;
        if (gcnt != 40 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL hold got=%0d want=40", gcnt);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(4) == 0) master_request[b] = ~master_request[b];
            tick();
            checks++;
            if (obs !== exp_vec() || $countones(hba_mgrant) > 1) begin
                errors++;
                $display("FAIL random c%0d req=%b got=%h want=%h", cyc, master_request, obs, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        master_request = 4'b0100;
        repeat (2) tick();
        #3;
        hba_reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        model_reset();
        @(posedge hba_clk);
        #1;
        hba_reset_n    = 1'b1;
        master_request = 4'b0101;
        tick();
        checks++;
        if (hba_mgrant !== 4'b0001 || grant_id !== 3'd0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset_prio got=%b want=0001", hba_mgrant);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_single_directed();
        test_rotation();
        test_pending();
`ifdef HBA_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_hold();
`endif
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hba_arbiter.md
HBA_ARBITER -- requirements
Module: hba_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 4, giving the number of HBA bus masters arbitrated (range 2..8).
REQ-002 The block SHALL have parameter WDOG_CYCLES, default 255, giving the maximum grant hold time in hba_clk cycles (range 1..65535).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port hba_clk, input, 1 bit: the bus clock; all logic is on its rising edge.
REQ-005 The block SHALL have port hba_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port master_request, input, NUM_MASTERS bits: bit i is master i's bus request.
REQ-007 The block SHALL have port hba_mgrant, output, NUM_MASTERS bits: one-hot-or-zero grant, registered.
REQ-008 The block SHALL have port grant_id, output, 3 bits: index of the granted master, 0 when none.
REQ-009 The block SHALL have port arb_busy, output, 1 bit: high while any grant is asserted.
REQ-010 The block SHALL have port arb_timeout, output, 1 bit: one-cycle pulse on watchdog revoke; present only with the macro defined.

Function
REQ-011 The block SHALL implement states IDLE, GRANT and GAP.
REQ-012 In IDLE with master_request (masked per REQ-016) nonzero, the block SHALL select the first requester strictly after last_owner, wrapping modulo NUM_MASTERS.
REQ-013 In IDLE, the selected grant bit SHALL assert on the clock edge after the request is sampled (1-cycle latency), with state going to GRANT and last_owner updated.
REQ-014 In GRANT, hba_mgrant SHALL stay constant while the owner's request stays high; other requests SHALL be ignored.
REQ-015 In GRANT, a low owner request SHALL clear hba_mgrant on the next edge and move to GAP; GAP SHALL last exactly 1 cycle with all grants 0, then go to IDLE.
REQ-016 With the macro defined, a grant held WDOG_CYCLES cycles SHALL be revoked: grants clear, arb_timeout pulses once, state goes to GAP, and the owner is blocked until its request goes low.
REQ-017 The watchdog counter SHALL be 16 bits, clear on entry to GRANT, and saturate rather than wrap.
REQ-018 A request going low in the same cycle as watchdog expiry SHALL be treated as a normal release (no arb_timeout pulse, no block).
REQ-019 A request asserted during GRANT or GAP SHALL be held pending and served in IDLE by round-robin order.
REQ-020 hba_mgrant SHALL never have more than one bit set; grant_id and arb_busy SHALL be registered and consistent with hba_mgrant in the same cycle.

Reset
REQ-021 On reset assertion, the block SHALL immediately clear hba_mgrant, grant_id, arb_busy, arb_timeout, the watchdog counter and the block mask, and go to IDLE.
REQ-022 On reset, last_owner SHALL be NUM_MASTERS-1, so master 0 has first priority after reset.
REQ-023 Reset asserted during GRANT SHALL drop the grant with no GAP cycle and no arb_timeout pulse.

Configuration
REQ-024 With macro HBA_ARB_WATCHDOG_EN defined, the watchdog, block mask and arb_timeout port SHALL be present.
REQ-025 Without HBA_ARB_WATCHDOG_EN, the watchdog SHALL be absent, grants SHALL be held indefinitely, and the arb_timeout port SHALL not exist.

Structure
REQ-026 Shared package hba_pkg SHALL hold the arbiter state enum (IDLE/GRANT/GAP), the NUM_MASTERS maximum (8) and the watchdog counter width (16).
REQ-027 Round-robin selection SHALL be a combinational sub-module hba_rr_picker (inputs: request vector, last_owner; outputs: one-hot pick, index, valid).

Verification
REQ-028 Test reset release then master_request=4'b0001 at cycle 0 -> hba_mgrant=4'b0001 at cycle 1 and grant_id=0; request low at cycle 5 -> grant 0 at cycle 6, then GAP.
REQ-029 Test master_request=4'b1111 held, each master dropping after 3 granted cycles -> grant order 0,1,2,3,0 with one all-zero cycle between grants.
REQ-030 Test master 2 owns the bus and master 1 requests -> master 1 is granted only after master 2 releases and GAP completes; grant_id=1.
REQ-031 Test with HBA_ARB_WATCHDOG_EN and WDOG_CYCLES=10, master 3 holds its request -> grant revoked after 10 cycles, arb_timeout pulses once, master 3 not re-granted until its request drops and rises again.
REQ-032 Test hba_reset_n low mid-GRANT -> hba_mgrant=0 immediately (asynchronous); after release, master 0 wins a simultaneous 4'b0101 request.
